// File: rtl/pipelined_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_alu_core
//  Purpose  : Four-stage pipelined ALU with an internal register file.
//             S1 latches the decoded instruction, S2 resolves operands
//             (forwarding from S3/S4 or the register file), S3 executes,
//             S4 is the output register. The register file is written on
//             the same edge that loads S4. Any result held without
//             result_ready freezes the whole pipe.
//  Ports    : clk          - clock, rising edge
//             reset        - asynchronous, active-low reset
//             instr_valid  - instruction offered
//             instr_ready  - instruction accepted on valid & ready
//             instr        - {opcode[2:0], rd, rs1, rs2}
//             instr_imm    - immediate for LOADI
//             result       - value written to rd
//             result_rd    - destination register of result
//             result_carry - ADD carry / SUB borrow, else 0
//             result_zero  - result == 0
//             result_valid - result fields valid
//             result_ready - consumer accepts result
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_alu_core #(
    parameter int  DATA_W    = 8,
    parameter int  REG_DEPTH = 8,
    localparam int RA        = $clog2(REG_DEPTH),
    localparam int IW        = 3 + 3 * RA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [IW-1:0]     instr,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] result,
    output logic [RA-1:0]     result_rd,
    output logic              result_carry,
    output logic              result_zero,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_MOV   = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    // Instruction field extraction
    logic [2:0]    in_op;
    logic [RA-1:0] in_rd;
    logic [RA-1:0] in_rs1;
    logic [RA-1:0] in_rs2;

    assign in_op  = instr[IW-1 -: 3];
    assign in_rd  = instr[3*RA-1 -: RA];
    assign in_rs1 = instr[2*RA-1 -: RA];
    assign in_rs2 = instr[RA-1:0];

    // Pipeline state
    logic              ready_q;

    logic              s1_valid_q;
    logic [2:0]        s1_op_q;
    logic [RA-1:0]     s1_rd_q;
    logic [RA-1:0]     s1_rs1_q;
    logic [RA-1:0]     s1_rs2_q;
    logic [DATA_W-1:0] s1_imm_q;

    logic              s2_valid_q;
    logic [2:0]        s2_op_q;
    logic [RA-1:0]     s2_rd_q;
    logic [RA-1:0]     s2_rs1_q;
    logic [RA-1:0]     s2_rs2_q;
    logic [DATA_W-1:0] s2_imm_q;

    logic              s3_valid_q;
    logic [2:0]        s3_op_q;
    logic [RA-1:0]     s3_rd_q;
    logic [DATA_W-1:0] s3_a_q;
    logic [DATA_W-1:0] s3_b_q;
    logic [DATA_W-1:0] s3_imm_q;

    logic              s4_valid_q;
    logic [DATA_W-1:0] s4_result_q;
    logic [RA-1:0]     s4_rd_q;
    logic              s4_carry_q;
    logic              s4_zero_q;

    logic [DATA_W-1:0] rf_q [REG_DEPTH];

    // Handshake: a held, unconsumed result freezes every stage.
    logic stall;
    logic advance;
    logic accept;

    assign stall       = s4_valid_q && !result_ready;
    assign advance     = !stall;
    assign instr_ready = ready_q && !stall;
    assign accept      = instr_valid && instr_ready;

    // S3 execute
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   add_full;

    assign add_full = {1'b0, s3_a_q} + {1'b0, s3_b_q};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (s3_op_q)
            OP_ADD: begin
                alu_res   = add_full[DATA_W-1:0];
                alu_carry = add_full[DATA_W];
            end
            OP_SUB: begin
                alu_res   = s3_a_q - s3_b_q;
                alu_carry = (s3_b_q > s3_a_q);
            end
            OP_AND:   alu_res = s3_a_q & s3_b_q;
            OP_OR:    alu_res = s3_a_q | s3_b_q;
            OP_LOADI: alu_res = s3_imm_q;
            OP_XOR:   alu_res = s3_a_q ^ s3_b_q;
            OP_MOV:   alu_res = s3_a_q;
            OP_NOP:   alu_res = '0;
        endcase
    end

    // S2 operand read. Later assignments override earlier ones, giving the
    // priority r0 > S3 ALU > S4 > register file. S4 and the register file
    // hold the same value (written on the same edge) except for r0, which
    // the final override keeps at zero.
    logic [RA-1:0]     src  [2];
    logic [DATA_W-1:0] opnd [2];

    assign src[0] = s2_rs1_q;
    assign src[1] = s2_rs2_q;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            opnd[k] = rf_q[src[k]];
            if (s4_valid_q && (s4_rd_q == src[k])) begin
                opnd[k] = s4_result_q;
            end
            if (s3_valid_q && (s3_rd_q == src[k])) begin
                opnd[k] = alu_res;
            end
            if (src[k] == '0) begin
                opnd[k] = '0;
            end
        end
    end

    // instr_ready rises on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_op_q     <= '0;
            s2_rd_q     <= '0;
            s2_rs1_q    <= '0;
            s2_rs2_q    <= '0;
            s2_imm_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_op_q     <= '0;
            s3_rd_q     <= '0;
            s3_a_q      <= '0;
            s3_b_q      <= '0;
            s3_imm_q    <= '0;
            s4_valid_q  <= 1'b0;
            s4_result_q <= '0;
            s4_rd_q     <= '0;
            s4_carry_q  <= 1'b0;
            s4_zero_q   <= 1'b0;
        end else if (advance) begin
            // A NOP is accepted but enters the pipe as a bubble.
            s1_valid_q <= accept && (in_op != OP_NOP);
            if (accept) begin
                s1_op_q  <= in_op;
                s1_rd_q  <= in_rd;
                s1_rs1_q <= in_rs1;
                s1_rs2_q <= in_rs2;
                s1_imm_q <= instr_imm;
            end

            s2_valid_q <= s1_valid_q;
            s2_op_q    <= s1_op_q;
            s2_rd_q    <= s1_rd_q;
            s2_rs1_q   <= s1_rs1_q;
            s2_rs2_q   <= s1_rs2_q;
            s2_imm_q   <= s1_imm_q;

            s3_valid_q <= s2_valid_q;
            s3_op_q    <= s2_op_q;
            s3_rd_q    <= s2_rd_q;
            s3_a_q     <= opnd[0];
            s3_b_q     <= opnd[1];
            s3_imm_q   <= s2_imm_q;

            s4_valid_q  <= s3_valid_q;
            s4_result_q <= alu_res;
            s4_rd_q     <= s3_rd_q;
            s4_carry_q  <= alu_carry;
            s4_zero_q   <= (alu_res == '0);
        end
    end

    // Register file: written as S3 moves into S4; r0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (advance && s3_valid_q && (s3_rd_q != '0)) begin
            rf_q[s3_rd_q] <= alu_res;
        end
    end

    assign result       = s4_result_q;
    assign result_rd    = s4_rd_q;
    assign result_carry = s4_carry_q;
    assign result_zero  = s4_zero_q;
    assign result_valid = s4_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_alu_core
//  Purpose  : Self-checking bench for pipelined_alu_core. Directed scenarios
//             followed by random traffic, checked against an architectural
//             reference model (sequential register array + expected queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu_core;

    localparam int DW = 8;
    localparam int RD = 8;
    localparam int RA = 3;

    localparam logic [2:0] L_ADD   = 3'd0;
    localparam logic [2:0] L_SUB   = 3'd1;
    localparam logic [2:0] L_LOADI = 3'd4;
    localparam logic [2:0] L_XOR   = 3'd5;
    localparam logic [2:0] L_MOV   = 3'd6;
    localparam logic [2:0] L_NOP   = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [3+3*RA-1:0] instr;
    logic [DW-1:0]     instr_imm;
    logic [DW-1:0]     result;
    logic [RA-1:0]     result_rd;
    logic              result_carry;
    logic              result_zero;
    logic              result_valid;
    logic              result_ready;

    pipelined_alu_core #(.DATA_W(DW), .REG_DEPTH(RD)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_imm    (instr_imm),
        .result       (result),
        .result_rd    (result_rd),
        .result_carry (result_carry),
        .result_zero  (result_zero),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        logic [RA-1:0] rd;
        logic          c;
        logic          z;
        int            c0;
        int            st0;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] rf_m [RD];
    logic [DW-1:0] hist_res [$];
    logic [RA-1:0] hist_rd [$];
    logic          hist_c [$];
    logic          hist_z [$];

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;
    bit hold_chk    = 0;
    logic [DW-1:0] h_res;
    logic [RA-1:0] h_rd;
    logic          h_c, h_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural model: instructions execute one at a time in program order.
    function automatic exp_t model(input logic [2:0] op, input logic [RA-1:0] rd,
                                   input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                                   input logic [DW-1:0] imm);
        exp_t e;
        int a, b, r;
        a   = int'(rf_m[rs1]);
        b   = int'(rf_m[rs2]);
        e.c = 1'b0;
        case (op)
            3'd0: begin r = a + b; e.c = (r > 255); end
            3'd1: begin r = a - b; e.c = (b > a); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = int'(imm);
            3'd5: r = a ^ b;
            3'd6: r = a;
            default: r = 0;
        endcase
        r     = r & 255;
        e.res = r[DW-1:0];
        e.z   = (r == 0);
        e.rd  = rd;
        e.c0  = 0;
        e.st0 = 0;
        return e;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        for (int i = 0; i < RD; i++) rf_m[i] = '0;
    endfunction

    // One clock cycle: drive at the negedge, observe 1ns later, then advance.
    task automatic step(input bit v, input logic [2:0] op, input logic [RA-1:0] rd,
                        input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                        input logic [DW-1:0] imm, input bit rr);
        bit   stall;
        exp_t e;
        instr_valid  = v;
        instr        = {op, rd, rs1, rs2};
        instr_imm    = imm;
        result_ready = rr;
        #1;
        stall = result_valid && !result_ready;
        chk("instr_ready", instr_ready, !stall);
        if (hold_chk) begin
            chk("hold_valid", result_valid, 1);
            chk("hold_result", result, h_res);
            chk("hold_rd", result_rd, h_rd);
            chk("hold_carry", result_carry, h_c);
            chk("hold_zero", result_zero, h_z);
        end
        if (stall) begin
            hold_chk = 1;
            h_res = result; h_rd = result_rd; h_c = result_carry; h_z = result_zero;
            stalls++;
        end else begin
            hold_chk = 0;
        end
        if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("result_rd", result_rd, e.rd);
                chk("result_carry", result_carry, e.c);
                chk("result_zero", result_zero, e.z);
                chk("latency", cyc, e.c0 + 4 + (stalls - e.st0));
            end
            hist_res.push_back(result);
            hist_rd.push_back(result_rd);
            hist_c.push_back(result_carry);
            hist_z.push_back(result_zero);
        end
        if (instr_valid && instr_ready && op != L_NOP) begin
            e     = model(op, rd, rs1, rs2, imm);
            e.c0  = cyc;
            e.st0 = stalls;
            exp_q.push_back(e);
            if (rd != 0) rf_m[rd] = e.res;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (8) step(0, L_NOP, 0, 0, 0, 8'h00, 1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic void hist_clear();
        hist_res.delete(); hist_rd.delete(); hist_c.delete(); hist_z.delete();
    endfunction

    // Called at a negedge; asserts reset between clock edges.
    task automatic mid_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid", result_valid, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", result_rd, 0);
        chk("rst_carry", result_carry, 0);
        chk("rst_zero", result_zero, 0);
        model_clear();
        hold_chk = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_before_first_edge", instr_ready, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        instr_valid  = 1'b0;
        instr        = '0;
        instr_imm    = '0;
        result_ready = 1'b1;
        model_clear();
        #1;
        chk("init_valid", result_valid, 0);
        chk("init_ready", instr_ready, 0);
        chk("init_result", result, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_before_first_edge", instr_ready, 0);
        @(posedge clk);
        @(negedge clk);

        // LOADI r1,1; LOADI r2,2; ADD r3,r1,r2 back to back
        hist_clear();
        step(1, L_LOADI, 1, 0, 0, 8'h01, 1);
        step(1, L_LOADI, 2, 0, 0, 8'h02, 1);
        step(1, L_ADD,   3, 1, 2, 8'h00, 1);
        drain();
        chk("s031_count", hist_res.size(), 3);
        chk("s031_r0", hist_res[0], 8'h01);
        chk("s031_r1", hist_res[1], 8'h02);
        chk("s031_r2", hist_res[2], 8'h03);
        chk("s031_rd2", hist_rd[2], 3);

        // SUB r4,r1,r2 -> borrow
        hist_clear();
        step(1, L_SUB, 4, 1, 2, 8'h00, 1);
        drain();
        chk("s032_res", hist_res[0], 8'hFF);
        chk("s032_carry", hist_c[0], 1);
        chk("s032_zero", hist_z[0], 0);

        // ADD wrap to zero with carry
        hist_clear();
        step(1, L_LOADI, 5, 0, 0, 8'hFF, 1);
        step(1, L_LOADI, 6, 0, 0, 8'h01, 1);
        step(1, L_ADD,   7, 5, 6, 8'h00, 1);
        drain();
        chk("s033_res", hist_res[2], 8'h00);
        chk("s033_carry", hist_c[2], 1);
        chk("s033_zero", hist_z[2], 1);

        // Backpressure with four dependent instructions in flight
        hist_clear();
        step(1, L_LOADI, 1, 0, 0, 8'h10, 1);
        step(1, L_ADD,   2, 1, 1, 8'h00, 1);
        step(1, L_SUB,   3, 2, 1, 8'h00, 1);
        step(1, L_XOR,   4, 3, 2, 8'h00, 1);
        repeat (3) step(1, L_MOV, 5, 4, 0, 8'h00, 0);
        drain();
        chk("s034_count", hist_res.size(), 4);
        chk("s034_r0", hist_res[0], 8'h10);
        chk("s034_r1", hist_res[1], 8'h20);
        chk("s034_r2", hist_res[2], 8'h10);
        chk("s034_r3", hist_res[3], 8'h30);

        // Writes to r0 are emitted but never stored
        hist_clear();
        step(1, L_LOADI, 0, 0, 0, 8'hAA, 1);
        step(1, L_MOV,   1, 0, 0, 8'h00, 1);
        drain();
        chk("s035_res0", hist_res[0], 8'hAA);
        chk("s035_rd0", hist_rd[0], 0);
        chk("s035_res1", hist_res[1], 8'h00);

        // Reset with three instructions in flight
        step(1, L_LOADI, 1, 0, 0, 8'h05, 1);
        drain();
        step(1, L_LOADI, 1, 0, 0, 8'h77, 1);
        step(1, L_LOADI, 3, 0, 0, 8'h12, 1);
        step(1, L_LOADI, 4, 0, 0, 8'h34, 1);
        step(0, L_NOP,   0, 0, 0, 8'h00, 0);
        mid_reset();
        hist_clear();
        step(1, L_MOV, 2, 1, 0, 8'h00, 1);
        drain();
        chk("s036_count", hist_res.size(), 1);
        chk("s036_res", hist_res[0], 8'h00);
        chk("s036_rd", hist_rd[0], 2);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 8,
                 3'($urandom_range(0, 7)),
                 RA'($urandom_range(0, RD - 1)),
                 RA'($urandom_range(0, RD - 1)),
                 RA'($urandom_range(0, RD - 1)),
                 DW'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
